// File: rtl/uart_rx_frame_check.sv
// UART receive-frame checker.
// Captures an assembled word and its parity bit when the deserialiser
// signals the end of the data bits. It then checks the stop bit(s) on the
// oversampled serial line and delivers the word with its error flags through
// a one-entry valid/ready holding register that detects overrun.
module uart_rx_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_datain,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_parity,
   input  logic                  checkstop,
   output logic [DATA_WIDTH-1:0] rx_dataout,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  stop_error,
   output logic                  parity_error,
   output logic                  overrun_error,
   output logic                  busy
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic          BIT_LAST = 1'(STOP_BITS - 1);

   typedef enum logic {IDLE, STOP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  bit_q, bit_d;
   logic                  complete;
   logic                  ferr;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  perr_q;

   // State register with sample counter and stop-bit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
      end
   end

   // Next-state logic: a low sample aborts the frame immediately
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      complete = 1'b0;
      ferr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (checkstop) begin
               state_d = STOP;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         STOP: begin
            if (!rx_datain) begin
               complete = 1'b1;
               ferr     = 1'b1;
               state_d  = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               if (bit_q == BIT_LAST) begin
                  complete = 1'b1;
                  state_d  = IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == STOP);
   end

   // Capture the word and its parity verdict at the start of the stop period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         perr_q <= 1'b0;
      end else if (state_q == IDLE && checkstop) begin
         data_q <= rx_data;
         perr_q <= (PARITY_EN != 0) && ((^{rx_data, rx_parity}) != (PARITY_ODD != 0));
      end
   end

   // Holding register: load on completion, release on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_dataout    <= '0;
         rx_valid      <= 1'b0;
         stop_error    <= 1'b0;
         parity_error  <= 1'b0;
         overrun_error <= 1'b0;
      end else if (complete) begin
         rx_dataout    <= ferr ? '0 : data_q;
         stop_error    <= ferr;
         parity_error  <= perr_q;
         overrun_error <= rx_valid & ~rx_ready;
         rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
         rx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed testbench for uart_rx_frame_check. Four instances share the
// stimulus: defaults, odd parity, parity disabled, and two stop bits at
// 16x oversampling.
module tb_uart_rx_frame_check;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_datain = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_parity = 1'b0;
   logic       checkstop = 1'b0;
   logic       rx_ready = 1'b1;

   logic [7:0] def_dout, odd_dout, nop_dout, s2_dout;
   logic def_valid, def_serr, def_perr, def_oerr, def_busy;
   logic odd_valid, odd_serr, odd_perr, odd_oerr, odd_busy;
   logic nop_valid, nop_serr, nop_perr, nop_oerr, nop_busy;
   logic s2_valid, s2_serr, s2_perr, s2_oerr, s2_busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_rx_frame_check u_def (
      .clk(clk), .rst_n(rst_n), .rx_datain(rx_datain), .rx_data(rx_data),
      .rx_parity(rx_parity), .checkstop(checkstop), .rx_dataout(def_dout),
      .rx_valid(def_valid), .rx_ready(rx_ready), .stop_error(def_serr),
      .parity_error(def_perr), .overrun_error(def_oerr), .busy(def_busy));

   uart_rx_frame_check #(.PARITY_ODD(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .rx_datain(rx_datain), .rx_data(rx_data),
      .rx_parity(rx_parity), .checkstop(checkstop), .rx_dataout(odd_dout),
      .rx_valid(odd_valid), .rx_ready(rx_ready), .stop_error(odd_serr),
      .parity_error(odd_perr), .overrun_error(odd_oerr), .busy(odd_busy));

   uart_rx_frame_check #(.PARITY_EN(0)) u_nop (
      .clk(clk), .rst_n(rst_n), .rx_datain(rx_datain), .rx_data(rx_data),
      .rx_parity(rx_parity), .checkstop(checkstop), .rx_dataout(nop_dout),
      .rx_valid(nop_valid), .rx_ready(rx_ready), .stop_error(nop_serr),
      .parity_error(nop_perr), .overrun_error(nop_oerr), .busy(nop_busy));

   uart_rx_frame_check #(.STOP_BITS(2), .OVERSAMPLE(16)) u_s2 (
      .clk(clk), .rst_n(rst_n), .rx_datain(rx_datain), .rx_data(rx_data),
      .rx_parity(rx_parity), .checkstop(checkstop), .rx_dataout(s2_dout),
      .rx_valid(s2_valid), .rx_ready(rx_ready), .stop_error(s2_serr),
      .parity_error(s2_perr), .overrun_error(s2_oerr), .busy(s2_busy));

   // advance to 1 time unit past the next rising edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx_datain = 1'b1;
      checkstop = 1'b0;
      rx_ready = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   // issue checkstop; returns just after the checkstop edge
   task automatic start_frame(input logic [7:0] d, input logic p);
      rx_data = d;
      rx_parity = p;
      checkstop = 1'b1;
      tick(1);
      checkstop = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(2);
      checks++;
      if ({def_valid, def_dout, def_serr, def_perr, def_oerr, def_busy} !== 13'd0) begin
         failures++;
         $display("FAIL reset_state got=%b exp=0", {def_valid, def_dout, def_serr, def_perr, def_oerr, def_busy});
      end
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_defaults();
      logic bad_lat;
      do_reset();
      start_frame(8'hA5, 1'b0);
      checks++;
      if (def_busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_in_stop got=%b exp=1", def_busy);
      end
      bad_lat = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick(1);
         if (def_valid !== 1'b0) bad_lat = 1'b1;
      end
      checks++;
      if (bad_lat !== 1'b0) begin
         failures++;
         $display("FAIL early_valid got=1 exp=0 before edge 8");
      end
      tick(1);
      checks++;
      if ({def_valid, def_dout, def_serr, def_perr, def_oerr, def_busy} !== {1'b1, 8'hA5, 4'b0000}) begin
         failures++;
         $display("FAIL default_frame got=%b exp=%b", {def_valid, def_dout, def_serr, def_perr, def_oerr, def_busy}, {1'b1, 8'hA5, 4'b0000});
      end
      tick(1);
      checks++;
      if (def_valid !== 1'b0) begin
         failures++;
         $display("FAIL accept_clears_valid got=%b exp=0", def_valid);
      end
   endtask

   task automatic test_parity();
      do_reset();
      start_frame(8'hA5, 1'b1);
      tick(8);
      checks++;
      if ({def_valid, def_perr, def_dout} !== {2'b11, 8'hA5}) begin
         failures++;
         $display("FAIL parity_even_err got=%b/%b/%h exp=1/1/a5", def_valid, def_perr, def_dout);
      end
      checks++;
      if ({odd_valid, odd_perr} !== 2'b10) begin
         failures++;
         $display("FAIL parity_odd_ok got=%b/%b exp=1/0", odd_valid, odd_perr);
      end
      checks++;
      if ({nop_valid, nop_perr} !== 2'b10) begin
         failures++;
         $display("FAIL parity_disabled got=%b/%b exp=1/0", nop_valid, nop_perr);
      end
      start_frame(8'hA5, 1'b0);
      tick(8);
      checks++;
      if ({odd_valid, odd_perr, def_perr} !== 3'b110) begin
         failures++;
         $display("FAIL parity_odd_err got=%b/%b/%b exp=1/1/0", odd_valid, odd_perr, def_perr);
      end
   endtask

   task automatic test_framing();
      do_reset();
      start_frame(8'hA5, 1'b1);
      tick(2);
      checks++;
      if ({def_valid, def_busy} !== 2'b01) begin
         failures++;
         $display("FAIL frame_pre_low got=%b exp=01", {def_valid, def_busy});
      end
      rx_datain = 1'b0;
      tick(1);
      rx_datain = 1'b1;
      checks++;
      if ({def_valid, def_serr, def_perr, def_dout, def_busy} !== {3'b111, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL frame_low_edge3 got=%b exp=%b", {def_valid, def_serr, def_perr, def_dout, def_busy}, {3'b111, 8'h00, 1'b0});
      end
      // low on the very last sample still counts
      start_frame(8'h3C, 1'b0);
      tick(7);
      rx_datain = 1'b0;
      tick(1);
      rx_datain = 1'b1;
      checks++;
      if ({def_valid, def_serr, def_dout} !== {2'b11, 8'h00}) begin
         failures++;
         $display("FAIL frame_low_edge8 got=%b exp=%b", {def_valid, def_serr, def_dout}, {2'b11, 8'h00});
      end
   endtask

   task automatic test_two_stop();
      logic bad_lat;
      do_reset();
      start_frame(8'h5A, 1'b0);
      bad_lat = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         tick(1);
         if (s2_valid !== 1'b0 || s2_busy !== 1'b1) bad_lat = 1'b1;
      end
      checks++;
      if (bad_lat !== 1'b0) begin
         failures++;
         $display("FAIL s2_early got=1 exp=0 before edge 32");
      end
      tick(1);
      checks++;
      if ({s2_valid, s2_serr, s2_dout, s2_busy} !== {2'b10, 8'h5A, 1'b0}) begin
         failures++;
         $display("FAIL s2_clean got=%b exp=%b", {s2_valid, s2_serr, s2_dout, s2_busy}, {2'b10, 8'h5A, 1'b0});
      end
      tick(1);
      start_frame(8'h5A, 1'b0);
      tick(19);
      checks++;
      if ({s2_valid, s2_busy} !== 2'b01) begin
         failures++;
         $display("FAIL s2_pre_low got=%b exp=01", {s2_valid, s2_busy});
      end
      rx_datain = 1'b0;
      tick(1);
      rx_datain = 1'b1;
      checks++;
      if ({s2_valid, s2_serr, s2_dout, s2_busy} !== {2'b11, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL s2_low_edge20 got=%b exp=%b", {s2_valid, s2_serr, s2_dout, s2_busy}, {2'b11, 8'h00, 1'b0});
      end
   endtask

   task automatic test_overrun();
      do_reset();
      rx_ready = 1'b0;
      start_frame(8'h11, 1'b0);
      tick(8);
      tick(3);
      checks++;
      if ({def_valid, def_dout, def_oerr} !== {1'b1, 8'h11, 1'b0}) begin
         failures++;
         $display("FAIL hold_first got=%b exp=%b", {def_valid, def_dout, def_oerr}, {1'b1, 8'h11, 1'b0});
      end
      start_frame(8'h22, 1'b0);
      tick(8);
      checks++;
      if ({def_valid, def_dout, def_oerr} !== {1'b1, 8'h22, 1'b1}) begin
         failures++;
         $display("FAIL overrun_set got=%b exp=%b", {def_valid, def_dout, def_oerr}, {1'b1, 8'h22, 1'b1});
      end
      do_reset();
      rx_ready = 1'b0;
      start_frame(8'h11, 1'b0);
      tick(8);
      start_frame(8'h22, 1'b0);
      tick(7);
      rx_ready = 1'b1;
      tick(1);
      checks++;
      if ({def_valid, def_dout, def_oerr} !== {1'b1, 8'h22, 1'b0}) begin
         failures++;
         $display("FAIL accept_and_load got=%b exp=%b", {def_valid, def_dout, def_oerr}, {1'b1, 8'h22, 1'b0});
      end
      tick(1);
      checks++;
      if (def_valid !== 1'b0) begin
         failures++;
         $display("FAIL accept_after_load got=%b exp=0", def_valid);
      end
   endtask

   task automatic test_mid_reset();
      logic bad_idle;
      do_reset();
      rx_ready = 1'b0;
      start_frame(8'h77, 1'b1);
      tick(8);
      start_frame(8'hA5, 1'b1);
      tick(4);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({def_valid, def_dout, def_serr, def_perr, def_oerr, def_busy} !== 13'd0) begin
         failures++;
         $display("FAIL mid_reset got=%b exp=0", {def_valid, def_dout, def_serr, def_perr, def_oerr, def_busy});
      end
      tick(1);
      rst_n = 1'b1;
      bad_idle = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         if (def_valid !== 1'b0 || def_busy !== 1'b0) bad_idle = 1'b1;
      end
      checks++;
      if (bad_idle !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle got=1 exp=0");
      end
      rx_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_parity();
      test_framing();
      test_two_stop();
      test_overrun();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
